// File: rtl/ddr3_app_cmd_arbiter_pkg.sv
// Shared definitions for the DDR3 application command arbiter: MIG command
// encodings and the one-hot arbitration state.
package ddr3_app_cmd_arbiter_pkg;

    localparam logic [2:0] DDR3_CMD_WRITE = 3'b000;
    localparam logic [2:0] DDR3_CMD_READ  = 3'b001;

    localparam int ARB_IDLE_IDX = 0;
    localparam int ARB_WR_IDX   = 1;
    localparam int ARB_RD_IDX   = 2;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'b001 << ARB_IDLE_IDX,
        ARB_WR_OWN = 3'b001 << ARB_WR_IDX,
        ARB_RD_OWN = 3'b001 << ARB_RD_IDX
    } arb_state_t;

endpackage

// File: rtl/ddr3_app_cmd_arbiter_credit.sv
// Outstanding-read credit counter: counts read commands accepted by the MIG
// and not yet returned; flags a data_end that arrives with nothing outstanding.
module ddr3_rd_credit_cntr #(
    parameter int MAX_RD_OUT = 32,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             at_max,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_OUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (dec && (count == '0))
                underflow_err <= 1'b1;
            if (inc && !dec && (count != MAX_CNT))
                count <= count + 1'b1;
            else if (dec && !inc && (count != '0))
                count <= count - 1'b1;
        end
    end

    assign at_max = (count >= MAX_CNT);

endmodule

// File: rtl/ddr3_app_cmd_arbiter.sv
// Shares the MIG command port between the fill write controller and the readout
// request engine: write priority, bounded run lengths, capped outstanding reads.
module ddr3_app_cmd_arbiter
    import ddr3_app_cmd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 26,
    parameter int WR_MAX_RUN = 64,
    parameter int RD_MAX_RUN = 16,
    parameter int MAX_RD_OUT = 32,
    parameter int CNT_W      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_calib_done,
    input  logic              wr_req_en,
    input  logic [ADDR_W-1:0] wr_req_addr,
    output logic              wr_req_rdy,
    input  logic              rd_req_en,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_req_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic              app_rd_data_end,
    output logic [CNT_W-1:0]  rd_outstanding,
    output logic              grant_wr,
    output logic              grant_rd,
    output logic              rd_underflow_err
);

    localparam logic [CNT_W-1:0] WR_RUN_LAST = CNT_W'(WR_MAX_RUN - 1);
    localparam logic [CNT_W-1:0] RD_RUN_LAST = CNT_W'(RD_MAX_RUN - 1);
    localparam logic [CNT_W-1:0] RD_OUT_LAST = CNT_W'(MAX_RD_OUT - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] run_cnt;
    logic             rd_prio;
    logic             accept;
    logic             rd_at_max;
    logic             rd_ok;

    assign grant_wr   = state[ARB_WR_IDX];
    assign grant_rd   = state[ARB_RD_IDX];
    assign accept     = app_en & app_rdy;
    assign wr_req_rdy = grant_wr & accept;
    assign rd_req_rdy = grant_rd & accept;
    assign rd_ok      = rd_req_en & ~rd_at_max;

    // Command mux is combinational so the owner's request reaches the MIG in the same cycle.
    always_comb begin
        app_en   = 1'b0;
        app_cmd  = DDR3_CMD_WRITE;
        app_addr = '0;
        case (state)
            ARB_WR_OWN: begin
                app_en   = wr_req_en;
                app_addr = wr_req_addr;
            end
            ARB_RD_OWN: begin
                app_en   = rd_req_en;
                app_cmd  = DDR3_CMD_READ;
                app_addr = rd_req_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            run_cnt <= '0;
            rd_prio <= 1'b0;
        end else if (!init_calib_done) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (rd_prio && rd_ok) begin
                        state   <= ARB_RD_OWN;
                        run_cnt <= '0;
                        rd_prio <= 1'b0;
                    end else if (wr_req_en) begin
                        state   <= ARB_WR_OWN;
                        run_cnt <= '0;
                    end else if (rd_ok) begin
                        state   <= ARB_RD_OWN;
                        run_cnt <= '0;
                        rd_prio <= 1'b0;
                    end
                end
                ARB_WR_OWN: begin
                    if (!wr_req_en) begin
                        state <= ARB_IDLE;
                    end else if (accept) begin
                        if (run_cnt != WR_RUN_LAST)
                            run_cnt <= run_cnt + 1'b1;
                        // A full write run only yields when a read is actually waiting.
                        if ((run_cnt == WR_RUN_LAST) && rd_req_en) begin
                            state   <= ARB_IDLE;
                            rd_prio <= 1'b1;
                        end
                    end
                end
                ARB_RD_OWN: begin
                    if (!rd_req_en) begin
                        state <= ARB_IDLE;
                    end else if (accept) begin
                        if (run_cnt != RD_RUN_LAST)
                            run_cnt <= run_cnt + 1'b1;
                        if ((run_cnt == RD_RUN_LAST) || (rd_outstanding == RD_OUT_LAST))
                            state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    ddr3_rd_credit_cntr #(
        .MAX_RD_OUT (MAX_RD_OUT),
        .CNT_W      (CNT_W)
    ) u_rd_credit (
        .clk           (clk),
        .reset         (reset),
        .inc           (rd_req_rdy),
        .dec           (app_rd_data_end),
        .count         (rd_outstanding),
        .at_max        (rd_at_max),
        .underflow_err (rd_underflow_err)
    );

endmodule

// File: tb/tb_ddr3_app_cmd_arbiter.sv
// Directed bench for ddr3_app_cmd_arbiter: a per-cycle vector table plus short
// hand sequences for underflow, calibration loss and reset mid-grant.
module tb_ddr3_app_cmd_arbiter;

    localparam int ADDR_W = 26;
    localparam int CNT_W  = 7;

    logic              clk;
    logic              reset;
    logic              init_calib_done;
    logic              wr_req_en;
    logic [ADDR_W-1:0] wr_req_addr;
    logic              wr_req_rdy;
    logic              rd_req_en;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_rdy;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic              app_rd_data_end;
    logic [CNT_W-1:0]  rd_outstanding;
    logic              grant_wr;
    logic              grant_rd;
    logic              rd_underflow_err;

    ddr3_app_cmd_arbiter #(
        .ADDR_W     (ADDR_W),
        .WR_MAX_RUN (4),
        .RD_MAX_RUN (3),
        .MAX_RD_OUT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .init_calib_done  (init_calib_done),
        .wr_req_en        (wr_req_en),
        .wr_req_addr      (wr_req_addr),
        .wr_req_rdy       (wr_req_rdy),
        .rd_req_en        (rd_req_en),
        .rd_req_addr      (rd_req_addr),
        .rd_req_rdy       (rd_req_rdy),
        .app_en           (app_en),
        .app_cmd          (app_cmd),
        .app_addr         (app_addr),
        .app_rdy          (app_rdy),
        .app_rd_data_end  (app_rd_data_end),
        .rd_outstanding   (rd_outstanding),
        .grant_wr         (grant_wr),
        .grant_rd         (grant_rd),
        .rd_underflow_err (rd_underflow_err)
    );

    typedef struct packed {
        logic              cal;
        logic              wr_en;
        logic [ADDR_W-1:0] wa;
        logic              rd_en;
        logic [ADDR_W-1:0] ra;
        logic              rdy;
        logic              de;
    } in_t;

    typedef struct packed {
        logic              en;
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic              wrdy;
        logic              rrdy;
        logic              gw;
        logic              gr;
        logic [CNT_W-1:0]  ro;
        logic              err;
    } out_t;

    typedef struct packed {
        in_t  inp;
        out_t exp;
    } vec_t;

    vec_t tbl[$];
    out_t act;
    int   n_pass  = 0;
    int   n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic cal, input logic wr_en, input logic [ADDR_W-1:0] wa,
        input logic rd_en, input logic [ADDR_W-1:0] ra, input logic rdy, input logic de,
        input logic en, input logic [2:0] cmd, input logic [ADDR_W-1:0] addr,
        input logic wrdy, input logic rrdy, input logic gw, input logic gr,
        input logic [CNT_W-1:0] ro, input logic err);
        vec_t v;
        v.inp = '{cal, wr_en, wa, rd_en, ra, rdy, de};
        v.exp = '{en, cmd, addr, wrdy, rrdy, gw, gr, ro, err};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want)
            $display("FAIL %s: got %0h required %0h", name, got, want);
        else
            n_pass++;
    endtask

    function automatic out_t sample();
        return {app_en, app_cmd, app_addr, wr_req_rdy, rd_req_rdy,
                grant_wr, grant_rd, rd_outstanding, rd_underflow_err};
    endfunction

    initial begin
        reset = 1'b1;
        {init_calib_done, wr_req_en, wr_req_addr, rd_req_en, rd_req_addr, app_rdy, app_rd_data_end} = '0;

        // Write-only burst of ten, then release.
        tbl.push_back(mk(1,1,0,0,0,1,0, 0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1,1,26'(8*i),0,0,1,0, 1,3'b000,26'(8*i),1,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,0, 0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,0, 0,0,0,0,0,0,0,0,0));
        // Both requesting: 4 writes, IDLE, reads with priority, then writes first again.
        tbl.push_back(mk(1,1,'h200,1,'h300,1,0, 0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,1,26'('h200+8*k),1,'h300,1,0, 1,3'b000,26'('h200+8*k),1,0,1,0,0,0));
        tbl.push_back(mk(1,1,'h220,1,'h300,1,0, 0,0,0,0,0,0,0,0,0));
        for (int j = 0; j < 3; j++)
            tbl.push_back(mk(1,1,'h220,1,26'('h300+8*j),1,0, 1,3'b001,26'('h300+8*j),0,1,0,1,7'(j),0));
        tbl.push_back(mk(1,1,'h220,1,'h318,1,0, 0,0,0,0,0,0,0,3,0));
        tbl.push_back(mk(1,1,'h220,1,'h318,1,0, 1,3'b000,'h220,1,0,1,0,3,0));
        tbl.push_back(mk(1,0,0,1,'h318,1,0, 0,0,0,0,0,1,0,3,0));
        // Credit exhaustion, data_end return, simultaneous accept+data_end.
        tbl.push_back(mk(1,0,0,1,'h318,1,0, 0,0,0,0,0,0,0,3,0));
        tbl.push_back(mk(1,0,0,1,'h318,1,0, 1,3'b001,'h318,0,1,0,1,3,0));
        tbl.push_back(mk(1,0,0,1,'h320,1,0, 0,0,0,0,0,0,0,4,0));
        tbl.push_back(mk(1,0,0,1,'h320,1,1, 0,0,0,0,0,0,0,4,0));
        tbl.push_back(mk(1,0,0,1,'h320,1,0, 0,0,0,0,0,0,0,3,0));
        tbl.push_back(mk(1,0,0,1,'h320,1,1, 1,3'b001,'h320,0,1,0,1,3,0));
        tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,0,0,0,0,0,3,0));
        tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,0,0,0,0,0,2,0));
        tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,1,0, 0,0,0,0,0,0,0,0,0));
        // Stalled write holds address and grant while a read request appears.
        tbl.push_back(mk(1,1,'h100,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h100,0,0,0,0, 1,3'b000,'h100,0,0,1,0,0,0));
        for (int s = 0; s < 4; s++)
            tbl.push_back(mk(1,1,'h100,1,'h400,0,0, 1,3'b000,'h100,0,0,1,0,0,0));
        tbl.push_back(mk(1,1,'h100,1,'h400,1,0, 1,3'b000,'h100,1,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,1,'h400,1,0, 0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,1,'h400,1,0, 0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,'h400,0,0, 1,3'b001,'h400,0,0,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,3'b001,0,0,0,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));

        repeat (2) tick();
        #3;
        act = sample();
        chk("reset_outputs", {22'd0, act[9:0]} | {31'd0, |act}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            tick();
            {init_calib_done, wr_req_en, wr_req_addr, rd_req_en, rd_req_addr,
             app_rdy, app_rd_data_end} = tbl[i].inp;
            #3;
            act = sample();
            n_total++;
            if (act !== tbl[i].exp)
                $display("FAIL row%0d: got %h required %h", i, act, tbl[i].exp);
            else
                n_pass++;
        end

        // Underflow: data_end with nothing outstanding is sticky until reset.
        tick(); app_rd_data_end = 1'b1; #3;
        chk("err_before", 32'(rd_underflow_err), 32'd0);
        tick(); app_rd_data_end = 1'b0; #3;
        chk("ro_underflow", 32'(rd_outstanding), 32'd0);
        chk("err_set", 32'(rd_underflow_err), 32'd1);
        tick(); #3;
        chk("err_sticky", 32'(rd_underflow_err), 32'd1);

        // Calibration loss while owning with an unaccepted write.
        tick(); wr_req_en = 1'b1; wr_req_addr = 'h500; app_rdy = 1'b0; #3;
        chk("cal_idle", 32'(grant_wr), 32'd0);
        tick(); #3;
        chk("cal_grant", 32'({app_en, grant_wr}), 32'd3);
        chk("cal_addr", 32'(app_addr), 32'h500);
        tick(); init_calib_done = 1'b0; #3;
        tick(); #3;
        chk("cal_drop_en", 32'({app_en, grant_wr, grant_rd}), 32'd0);
        chk("cal_drop_err", 32'(rd_underflow_err), 32'd1);

        // One read outstanding, then reset mid write grant with app_rdy low.
        tick(); init_calib_done = 1'b1; wr_req_en = 1'b0; rd_req_en = 1'b1;
        rd_req_addr = 'h600; app_rdy = 1'b1; #3;
        tick(); #3;
        chk("rd_grant", 32'({grant_rd, rd_req_rdy, app_cmd}), 32'h19);
        chk("rd_addr", 32'(app_addr), 32'h600);
        tick(); rd_req_en = 1'b0; wr_req_en = 1'b1; wr_req_addr = 'h700; app_rdy = 1'b0; #3;
        chk("ro_one", 32'(rd_outstanding), 32'd1);
        tick(); #3;
        tick(); #3;
        chk("wr_hold", 32'({app_en, grant_wr, wr_req_rdy}), 32'd6);
        tick(); reset = 1'b1; init_calib_done = 1'b0; #3;
        tick(); reset = 1'b0; rd_req_en = 1'b1; #3;
        chk("rst_app_en", 32'({app_en, grant_wr, grant_rd}), 32'd0);
        chk("rst_ro", 32'(rd_outstanding), 32'd0);
        chk("rst_err", 32'(rd_underflow_err), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick(); #3;
            chk("nocal_app_en", 32'({app_en, grant_wr, grant_rd}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
